// File: rtl/routing_computation_adaptive_if.sv
// Route-computation request/result bundle between header decode and VC allocator.
// master = requester side, slave = route unit.
interface routing_computation_adaptive_if #(
  parameter int flit_size                    = 1,
  parameter int phit_size                    = 16,
  parameter int addr_length                  = 5,
  parameter int no_outport                   = 7,
  parameter int floorplusone_log2_no_outport = 3,
  parameter int no_vc                        = 4,
  parameter int floorplusone_log2_no_vc      = 3
);
  logic [flit_size*phit_size-1:0]                  header;
  logic                                            rc_req;
  logic                                            rc_ack;
  logic [no_outport*floorplusone_log2_no_vc-1:0]   busies;
  logic [addr_length-1:0]                          my_addr;
  logic [31:0]                                     node_links_directions;
  logic [floorplusone_log2_no_outport-1:0]         outport;
  logic [no_outport-1:0]                           outport_vec;
  logic [no_vc-1:0]                                allow_vcs;
  logic                                            rc_valid;
  logic                                            rc_busy;

  modport master (
    output header, rc_req, rc_ack, busies, my_addr,
    output node_links_directions,
    input  outport, outport_vec, allow_vcs, rc_valid, rc_busy
  );

  modport slave (
    input  header, rc_req, rc_ack, busies, my_addr,
    input  node_links_directions,
    output outport, outport_vec, allow_vcs, rc_valid, rc_busy
  );
endinterface

// File: rtl/routing_computation_adaptive.sv
// Registered 3-D mesh/torus route unit: XYZ, ZYX or minimal-adaptive, dateline VCs.
// Optional RC_ADAPT_STATS_EN adds adapt_count (adaptive picks differing from XYZ).
module routing_computation_adaptive #(
  parameter int cluster_topology                      = 0,
  parameter int cluster_first_dimension_up_bound      = 3,
  parameter int cluster_second_dimension_up_bound     = 3,
  parameter int cluster_third_dimension_up_bound      = 0,
  parameter int cluster_first_dimension_no_addr_bits  = 2,
  parameter int cluster_second_dimension_no_addr_bits = 2,
  parameter int cluster_third_dimension_no_addr_bits  = 1,
  parameter int addr_length                           = 5,
  parameter int addr_place_in_header                  = 0,
  parameter int flit_size                             = 1,
  parameter int phit_size                             = 16,
  parameter int no_outport                            = 7,
  parameter int floorplusone_log2_no_outport          = 3,
  parameter int no_vc                                 = 4,
  parameter int floorplusone_log2_no_vc               = 3,
  parameter int routing_mode                          = 0
) (
  input logic clk,
  input logic reset,
  routing_computation_adaptive_if.slave bus
`ifdef RC_ADAPT_STATS_EN
  ,
  output logic [15:0] adapt_count
`endif
);
  localparam int XB = cluster_first_dimension_no_addr_bits;
  localparam int YB = cluster_second_dimension_no_addr_bits;
  localparam int ZB = cluster_third_dimension_no_addr_bits;
  localparam int OW = floorplusone_log2_no_outport;
  localparam int BW = floorplusone_log2_no_vc;
  localparam int NO = no_outport;
  localparam int NV = no_vc;
  localparam int FW = flit_size * phit_size;
  localparam int UB [3] = '{cluster_first_dimension_up_bound,
                            cluster_second_dimension_up_bound,
                            cluster_third_dimension_up_bound};

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [addr_length-1:0] r_dst;
  logic [addr_length-1:0] r_cur;
  logic [NO*BW-1:0]       r_busies;
  logic [OW-1:0]          r_outport;
  logic [NO-1:0]          r_vec;
  logic [NV-1:0]          r_vcs;
  logic                   r_valid;
  logic                   r_busy;

  logic [FW-1:0]          w_hdr;
  int                     w_c [3];
  int                     w_d [3];
  logic [1:0]             w_code [3];
  logic [OW-1:0]          w_kport [3];
  logic [BW-1:0]          w_kbusy [3];
  logic [BW-1:0]          w_best;
  logic [1:0]             w_sel_xyz;
  logic [1:0]             w_sel_zyx;
  logic [1:0]             w_sel_ad;
  logic [1:0]             w_sel;
  logic                   w_local;
  logic                   w_wrap;
  logic [OW-1:0]          w_port;
  logic [NO-1:0]          w_vec;
  logic [NV-1:0]          w_vcs;
  logic                   w_unused;

  // {move, plus} for one dimension; torus takes the shorter way, tie goes +
  function automatic logic [1:0] f_dim(input int cur, input int dst, input int ring);
    int diff;
    int fwd;
    f_dim = 2'b00;
    diff  = dst - cur;
    if (cluster_topology == 0) begin
      if (diff > 0)      f_dim = 2'b11;
      else if (diff < 0) f_dim = 2'b10;
    end else begin
      fwd = (diff < 0) ? diff + ring : diff;
      if (fwd != 0) f_dim = (fwd <= ring - fwd) ? 2'b11 : 2'b10;
    end
  endfunction

  assign w_hdr    = bus.header;
  assign w_unused = ^{w_hdr, bus.node_links_directions};

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state: accept in IDLE, compute once, hold until acked
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.rc_req) w_next = CALC;
      CALC:    w_next = HOLD;
      HOLD:    if (bus.rc_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Route decision from latched coordinates and busy counts
  always_comb begin
    w_c[0] = int'(r_cur[0 +: XB]);
    w_c[1] = int'(r_cur[XB +: YB]);
    w_c[2] = int'(r_cur[XB+YB +: ZB]);
    w_d[0] = int'(r_dst[0 +: XB]);
    w_d[1] = int'(r_dst[XB +: YB]);
    w_d[2] = int'(r_dst[XB+YB +: ZB]);
    for (int i = 0; i < 3; i++) begin
      w_code[i]  = f_dim(w_c[i], w_d[i], UB[i] + 1);
      w_kport[i] = OW'(bus.node_links_directions[8*i + (w_code[i][0] ? 0 : 4) +: 4]);
      w_kbusy[i] = (int'(w_kport[i]) < NO) ?
                   r_busies[int'(w_kport[i])*BW +: BW] : '1;
    end
    w_sel_xyz = 2'd3;
    for (int i = 2; i >= 0; i--) if (w_code[i][1]) w_sel_xyz = 2'(i);
    w_sel_zyx = 2'd3;
    for (int i = 0; i < 3; i++) if (w_code[i][1]) w_sel_zyx = 2'(i);
    w_sel_ad = 2'd3;
    w_best   = '1;
    for (int i = 0; i < 3; i++) begin
      if (w_code[i][1] && (w_sel_ad == 2'd3 || w_kbusy[i] < w_best)) begin
        w_sel_ad = 2'(i);
        w_best   = w_kbusy[i];
      end
    end
    if (routing_mode == 2)      w_sel = w_sel_ad;
    else if (routing_mode == 1) w_sel = w_sel_zyx;
    else                        w_sel = w_sel_xyz;
    w_local = (w_sel == 2'd3);
    w_port  = '0;
    w_wrap  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (w_sel == 2'(i)) begin
        w_port = w_kport[i];
        w_wrap = (cluster_topology == 1) &&
                 (w_code[i][0] ? (w_c[i] == UB[i]) : (w_c[i] == 0));
      end
    end
    for (int v = 0; v < NV; v++) begin
      if (w_local || cluster_topology == 0) w_vcs[v] = 1'b1;
      else if (w_wrap)                      w_vcs[v] = (v >= NV / 2);
      else                                  w_vcs[v] = (v < NV / 2);
    end
    for (int p = 0; p < NO; p++) w_vec[p] = (int'(w_port) == p);
  end

  // Latch request, register the result, clear on ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dst     <= '0;
      r_cur     <= '0;
      r_busies  <= '0;
      r_outport <= '0;
      r_vec     <= '0;
      r_vcs     <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.rc_req) begin
          r_dst    <= w_hdr[addr_place_in_header +: addr_length];
          r_cur    <= bus.my_addr;
          r_busies <= bus.busies;
          r_busy   <= 1'b1;
        end
        CALC: begin
          r_outport <= w_port;
          r_vec     <= w_vec;
          r_vcs     <= w_vcs;
          r_valid   <= 1'b1;
        end
        HOLD: if (bus.rc_ack) begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.outport     = r_outport;
  assign bus.outport_vec = r_vec;
  assign bus.allow_vcs   = r_vcs;
  assign bus.rc_valid    = r_valid;
  assign bus.rc_busy     = r_busy;

`ifdef RC_ADAPT_STATS_EN
  logic [15:0] r_adapt;

  // Saturating count of adaptive picks that leave XYZ order
  always_ff @(posedge clk) begin
    if (reset) r_adapt <= '0;
    else if (r_state == CALC && routing_mode == 2 &&
             w_sel != w_sel_xyz && r_adapt != 16'hFFFF)
      r_adapt <= r_adapt + 16'd1;
  end

  assign adapt_count = r_adapt;
`endif
endmodule

// File: tb/tb_routing_computation_adaptive.sv
// Bench: five configurations (mesh XYZ/ZYX/adaptive, torus XYZ/adaptive) on shared stimulus.
// Expected results come from a coordinate-level routing model.
module tb_routing_computation_adaptive;
  localparam int NI = 5;
  localparam int TOPO [NI] = '{0, 0, 0, 1, 1};
  localparam int MODE [NI] = '{0, 1, 2, 0, 2};
  localparam logic [31:0] LID = 32'h0065_4321;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] header = '0;
  logic        rc_req = 1'b0;
  logic        rc_ack = 1'b0;
  logic [20:0] busies = '0;
  logic [4:0]  my_addr = '0;
  logic [31:0] links = LID;

  logic [2:0]  o_port  [NI];
  logic [6:0]  o_vec   [NI];
  logic [3:0]  o_vcs   [NI];
  logic        o_valid [NI];
  logic        o_busy  [NI];
  logic [15:0] adapt   [NI];

  int       checks = 0;
  int       errors = 0;
  int       exp_adapt [NI];
  int       ep [NI];
  logic [3:0] ev [NI];
  bit       ea [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    routing_computation_adaptive_if b ();
    assign b.header                = header;
    assign b.rc_req                = rc_req;
    assign b.rc_ack                = rc_ack;
    assign b.busies                = busies;
    assign b.my_addr               = my_addr;
    assign b.node_links_directions = links;
    assign o_port[g]  = b.outport;
    assign o_vec[g]   = b.outport_vec;
    assign o_vcs[g]   = b.allow_vcs;
    assign o_valid[g] = b.rc_valid;
    assign o_busy[g]  = b.rc_busy;
`ifndef RC_ADAPT_STATS_EN
    assign adapt[g] = '0;
`endif
    routing_computation_adaptive #(
      .cluster_topology(TOPO[g]),
      .cluster_third_dimension_up_bound(1),
      .routing_mode(MODE[g])
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .bus(b)
`ifdef RC_ADAPT_STATS_EN
      ,
      .adapt_count(adapt[g])
`endif
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coordinates x=[1:0], y=[3:2], z=[4]; rings 4,4,2
  function automatic void model(input int g, input logic [4:0] cur, input logic [4:0] dst,
                                input logic [20:0] bz, input logic [31:0] lk,
                                output int port, output logic [3:0] vcs, output bit adp);
    int c [3];
    int d [3];
    int ring [3];
    int dirn [3];
    int first, pick, best, k, b, p, diff, fwd;
    c[0] = int'(cur[1:0]); c[1] = int'(cur[3:2]); c[2] = int'(cur[4]);
    d[0] = int'(dst[1:0]); d[1] = int'(dst[3:2]); d[2] = int'(dst[4]);
    ring = '{4, 4, 2};
    for (int i = 0; i < 3; i++) begin
      diff = d[i] - c[i];
      if (TOPO[g] == 0) dirn[i] = (diff > 0) ? 1 : ((diff < 0) ? -1 : 0);
      else begin
        fwd = ((diff % ring[i]) + ring[i]) % ring[i];
        dirn[i] = (fwd == 0) ? 0 : ((2 * fwd <= ring[i]) ? 1 : -1);
      end
    end
    first = -1;
    for (int i = 0; i < 3; i++) if (first < 0 && dirn[i] != 0) first = i;
    pick = -1;
    if (MODE[g] == 0) pick = first;
    else if (MODE[g] == 1) begin
      for (int i = 2; i >= 0; i--) if (pick < 0 && dirn[i] != 0) pick = i;
    end else begin
      best = 1000;
      for (int i = 0; i < 3; i++) begin
        if (dirn[i] != 0) begin
          k = 2 * i + ((dirn[i] > 0) ? 1 : 2);
          p = int'((lk >> (4 * (k - 1))) & 32'hF);
          b = int'((bz >> (3 * p)) & 21'h7);
          if (b < best) begin best = b; pick = i; end
        end
      end
    end
    adp = (MODE[g] == 2) && (pick != first);
    if (pick < 0) begin
      port = 0;
      vcs  = 4'hF;
    end else begin
      k = 2 * pick + ((dirn[pick] > 0) ? 1 : 2);
      port = int'((lk >> (4 * (k - 1))) & 32'hF);
      if (TOPO[g] == 0) vcs = 4'hF;
      else if ((dirn[pick] > 0 && c[pick] == ring[pick] - 1) ||
               (dirn[pick] < 0 && c[pick] == 0)) vcs = 4'b1100;
      else vcs = 4'b0011;
    end
  endfunction

  function automatic logic [6:0] evec(input int p);
    return (p < 7) ? 7'(1 << p) : 7'b0;
  endfunction

  function automatic void predict(input logic [4:0] cur, input logic [4:0] dst,
                                  input logic [20:0] bz, input logic [31:0] lk);
    for (int g = 0; g < NI; g++) model(g, cur, dst, bz, lk, ep[g], ev[g], ea[g]);
  endfunction

  task automatic drive(input logic [4:0] cur, input logic [4:0] dst,
                       input logic [20:0] bz, input logic [31:0] lk);
    my_addr = cur;
    header  = {11'($urandom), dst};
    busies  = bz;
    links   = lk;
    rc_req  = 1'b1;
    tick();
    rc_req  = 1'b0;
    busies  = 21'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    for (int g = 0; g < NI; g++) begin
      checks += 5;
      if (o_valid[g] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %b want 0", g, o_valid[g]); end
      if (o_busy[g] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", g, o_busy[g]); end
      if (o_port[g] !== 3'd0) begin errors++; $display("FAIL reset_port[%0d] got %0d want 0", g, o_port[g]); end
      if (o_vec[g] !== 7'd0) begin errors++; $display("FAIL reset_vec[%0d] got %b want 0", g, o_vec[g]); end
      if (o_vcs[g] !== 4'd0) begin errors++; $display("FAIL reset_vcs[%0d] got %b want 0", g, o_vcs[g]); end
      exp_adapt[g] = 0;
`ifdef RC_ADAPT_STATS_EN
      checks++;
      if (adapt[g] !== 16'd0) begin errors++; $display("FAIL reset_adapt[%0d] got %0d want 0", g, adapt[g]); end
`endif
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [4:0]  tc [7] = '{5'd5, 5'd5, 5'd5, 5'd3, 5'd1, 5'd5, 5'd5};
    logic [4:0]  td [7] = '{5'd3, 5'd15, 5'd15, 5'd0, 5'd3, 5'd5, 5'd7};
    logic [20:0] tb [7] = '{21'd0, 21'd536, 21'd1040, 21'd0, 21'd0, 21'd0, 21'd0};
    logic [31:0] tl [7] = '{LID, LID, LID, LID, LID, LID, 32'h0065_4327};
    int          hi [7] = '{0, 2, 2, 3, 3, 0, 0};
    int          hp [7] = '{1, 3, 1, 1, 1, 0, 7};
    logic [3:0]  hc [7] = '{4'hF, 4'hF, 4'hF, 4'hC, 4'h3, 4'hF, 4'hF};
    logic [6:0]  hv [7] = '{7'b0000010, 7'b0001000, 7'b0000010, 7'b0000010,
                            7'b0000010, 7'b0000001, 7'b0000000};
    for (int t = 0; t < 7; t++) begin
      predict(tc[t], td[t], tb[t], tl[t]);
      drive(tc[t], td[t], tb[t], tl[t]);
      for (int g = 0; g < NI; g++) begin
        checks += 2;
        if (o_busy[g] !== 1'b1) begin errors++; $display("FAIL dir_busy_rise[%0d] t%0d got %b want 1", g, t, o_busy[g]); end
        if (o_valid[g] !== 1'b0) begin errors++; $display("FAIL dir_early_valid[%0d] t%0d got %b want 0", g, t, o_valid[g]); end
      end
      tick();
      for (int g = 0; g < NI; g++) begin
        checks += 4;
        if (o_valid[g] !== 1'b1) begin errors++; $display("FAIL dir_valid[%0d] t%0d got %b want 1", g, t, o_valid[g]); end
        if (o_port[g] !== 3'(ep[g])) begin errors++; $display("FAIL dir_port[%0d] t%0d got %0d want %0d", g, t, o_port[g], ep[g]); end
        if (o_vec[g] !== evec(ep[g])) begin errors++; $display("FAIL dir_vec[%0d] t%0d got %b want %b", g, t, o_vec[g], evec(ep[g])); end
        if (o_vcs[g] !== ev[g]) begin errors++; $display("FAIL dir_vcs[%0d] t%0d got %b want %b", g, t, o_vcs[g], ev[g]); end
        if (ea[g]) exp_adapt[g]++;
`ifdef RC_ADAPT_STATS_EN
        checks++;
        if (adapt[g] !== 16'(exp_adapt[g])) begin errors++; $display("FAIL dir_adapt[%0d] t%0d got %0d want %0d", g, t, adapt[g], exp_adapt[g]); end
`endif
      end
      checks += 3;
      if (o_port[hi[t]] !== 3'(hp[t])) begin errors++; $display("FAIL plan_port t%0d got %0d want %0d", t, o_port[hi[t]], hp[t]); end
      if (o_vec[hi[t]] !== hv[t]) begin errors++; $display("FAIL plan_vec t%0d got %b want %b", t, o_vec[hi[t]], hv[t]); end
      if (o_vcs[hi[t]] !== hc[t]) begin errors++; $display("FAIL plan_vcs t%0d got %b want %b", t, o_vcs[hi[t]], hc[t]); end
      rc_ack = 1'b1;
      tick();
      rc_ack = 1'b0;
      for (int g = 0; g < NI; g++) begin
        checks += 2;
        if (o_valid[g] !== 1'b0) begin errors++; $display("FAIL dir_ack_valid[%0d] t%0d got %b want 0", g, t, o_valid[g]); end
        if (o_busy[g] !== 1'b0) begin errors++; $display("FAIL dir_ack_busy[%0d] t%0d got %b want 0", g, t, o_busy[g]); end
      end
    end
  endtask

  task automatic test_hold();
    drive(5'd5, 5'd5, 21'd0, LID);
    tick();
    for (int c = 0; c < 5; c++) begin
      checks += 2;
      if (o_valid[0] !== 1'b1) begin errors++; $display("FAIL hold_valid c%0d got %b want 1", c, o_valid[0]); end
      if (o_vec[0] !== 7'b0000001) begin errors++; $display("FAIL hold_vec c%0d got %b want 0000001", c, o_vec[0]); end
      rc_req = (c == 1);
      header = 16'h0003;
      tick();
    end
    rc_req = 1'b1;
    rc_ack = 1'b1;
    tick();
    rc_req = 1'b0;
    rc_ack = 1'b0;
    checks += 2;
    if (o_valid[0] !== 1'b0) begin errors++; $display("FAIL hold_ack_valid got %b want 0", o_valid[0]); end
    if (o_busy[0] !== 1'b0) begin errors++; $display("FAIL hold_ack_busy got %b want 0", o_busy[0]); end
    tick();
    tick();
    checks += 2;
    if (o_busy[0] !== 1'b0) begin errors++; $display("FAIL ack_req_ignored_busy got %b want 0", o_busy[0]); end
    if (o_valid[0] !== 1'b0) begin errors++; $display("FAIL ack_req_ignored_valid got %b want 0", o_valid[0]); end
    drive(5'd5, 5'd3, 21'd0, LID);
    tick();
    checks += 2;
    if (o_valid[0] !== 1'b1) begin errors++; $display("FAIL reaccept_valid got %b want 1", o_valid[0]); end
    if (o_port[0] !== 3'd1) begin errors++; $display("FAIL reaccept_port got %0d want 1", o_port[0]); end
    rc_ack = 1'b1;
    tick();
    rc_ack = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    drive(5'd5, 5'd15, 21'd536, LID);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int g = 0; g < NI; g++) begin
      checks += 4;
      if (o_valid[g] !== 1'b0) begin errors++; $display("FAIL rih_valid[%0d] got %b want 0", g, o_valid[g]); end
      if (o_busy[g] !== 1'b0) begin errors++; $display("FAIL rih_busy[%0d] got %b want 0", g, o_busy[g]); end
      if (o_vcs[g] !== 4'd0) begin errors++; $display("FAIL rih_vcs[%0d] got %b want 0", g, o_vcs[g]); end
      if (o_port[g] !== 3'd0) begin errors++; $display("FAIL rih_port[%0d] got %0d want 0", g, o_port[g]); end
      exp_adapt[g] = 0;
`ifdef RC_ADAPT_STATS_EN
      checks++;
      if (adapt[g] !== 16'd0) begin errors++; $display("FAIL rih_adapt[%0d] got %0d want 0", g, adapt[g]); end
`endif
    end
    predict(5'd1, 5'd3, 21'd0, LID);
    drive(5'd1, 5'd3, 21'd0, LID);
    tick();
    for (int g = 0; g < NI; g++) begin
      checks += 3;
      if (o_valid[g] !== 1'b1) begin errors++; $display("FAIL rih_fresh_valid[%0d] got %b want 1", g, o_valid[g]); end
      if (o_port[g] !== 3'(ep[g])) begin errors++; $display("FAIL rih_fresh_port[%0d] got %0d want %0d", g, o_port[g], ep[g]); end
      if (o_vcs[g] !== ev[g]) begin errors++; $display("FAIL rih_fresh_vcs[%0d] got %b want %b", g, o_vcs[g], ev[g]); end
      if (ea[g]) exp_adapt[g]++;
    end
    rc_ack = 1'b1;
    tick();
    rc_ack = 1'b0;
  endtask

  task automatic test_random();
    int p [6];
    int j, tmp, hold;
    logic [4:0]  cur, dst;
    logic [20:0] bz;
    logic [31:0] lk;
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < 6; i++) p[i] = i + 1;
      for (int i = 5; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = p[i]; p[i] = p[j]; p[j] = tmp;
      end
      lk = $urandom;
      for (int i = 0; i < 6; i++) lk[4*i +: 4] = 4'(p[i]);
      bz = '0;
      for (int i = 0; i < 7; i++) bz[3*i +: 3] = 3'($urandom_range(0, 4));
      cur = 5'($urandom);
      dst = (n % 8 == 0) ? cur : 5'($urandom);
      predict(cur, dst, bz, lk);
      drive(cur, dst, bz, lk);
      tick();
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h <= hold; h++) begin
        for (int g = 0; g < NI; g++) begin
          checks += 4;
          if (o_valid[g] !== 1'b1) begin errors++; $display("FAIL rnd_valid[%0d] n%0d got %b want 1", g, n, o_valid[g]); end
          if (o_port[g] !== 3'(ep[g])) begin errors++; $display("FAIL rnd_port[%0d] n%0d got %0d want %0d", g, n, o_port[g], ep[g]); end
          if (o_vec[g] !== evec(ep[g])) begin errors++; $display("FAIL rnd_vec[%0d] n%0d got %b want %b", g, n, o_vec[g], evec(ep[g])); end
          if (o_vcs[g] !== ev[g]) begin errors++; $display("FAIL rnd_vcs[%0d] n%0d got %b want %b", g, n, o_vcs[g], ev[g]); end
          if (h == 0 && ea[g]) exp_adapt[g]++;
`ifdef RC_ADAPT_STATS_EN
          checks++;
          if (adapt[g] !== 16'(exp_adapt[g])) begin errors++; $display("FAIL rnd_adapt[%0d] n%0d got %0d want %0d", g, n, adapt[g], exp_adapt[g]); end
`endif
        end
        if (h < hold) begin
          rc_req = 1'($urandom);
          header = 16'($urandom);
          tick();
          rc_req = 1'b0;
        end
      end
      rc_ack = 1'b1;
      rc_req = 1'($urandom);
      tick();
      rc_ack = 1'b0;
      rc_req = 1'b0;
      for (int g = 0; g < NI; g++) begin
        checks += 2;
        if (o_valid[g] !== 1'b0) begin errors++; $display("FAIL rnd_ack_valid[%0d] n%0d got %b want 0", g, n, o_valid[g]); end
        if (o_busy[g] !== 1'b0) begin errors++; $display("FAIL rnd_ack_busy[%0d] n%0d got %b want 0", g, n, o_busy[g]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
